// File: rtl/ibex_wb_result_buffer.sv
// ibex_wb_result_buffer
//
// Writeback-side result buffer that sits directly after the execution block.
// Completed EX results that target a non-zero register are queued in order.
// The queue drains into the register file write port whenever that port is
// granted; the LSU shares the port, so it can be busy. Queued results that
// have not been written yet can be looked up by ID so that operand reads
// stay coherent. EX is back-pressured while the buffer is full.
//
// Optional build macro:
//   IBEX_WB_BYPASS_EN - when defined, a result that arrives while the buffer
//                       is empty and the port is granted goes straight to the
//                       register file in the same cycle instead of being
//                       queued. The default build (macro undefined) has no
//                       bypass, and every rf_* output comes from registers.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   ex_valid_i/ex_we_i              EX result valid / targets a register
//   ex_rd_addr_i/ex_result_i        destination register and value
//   ex_ready_o                      buffer can take a result this cycle
//   flush_i                         discard every queued result
//   rf_we_o/rf_waddr_o/rf_wdata_o   register file write request (head entry)
//   rf_ready_i                      register file port granted this cycle
//   fwd_raddr_{a,b}_i               ID operand registers to look up
//   fwd_hit_{a,b}_o/fwd_data_{a,b}_o youngest queued match for each operand
//   count_o                         number of occupied entries
module ibex_wb_result_buffer #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ex_valid_i,
  input  logic                         ex_we_i,
  input  logic [4:0]                   ex_rd_addr_i,
  input  logic [DataWidth-1:0]         ex_result_i,
  output logic                         ex_ready_o,
  input  logic                         flush_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [DataWidth-1:0]         rf_wdata_o,
  input  logic                         rf_ready_i,
  input  logic [4:0]                   fwd_raddr_a_i,
  input  logic [4:0]                   fwd_raddr_b_i,
  output logic                         fwd_hit_a_o,
  output logic [DataWidth-1:0]         fwd_data_a_o,
  output logic                         fwd_hit_b_o,
  output logic [DataWidth-1:0]         fwd_data_b_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [4:0]           rd_q   [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [Depth-1:0]     valid_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic has_data;
  logic accept;
  logic enq_req;
  logic push;
  logic pop;

  logic [PtrW-1:0] fwd_idx;

  assign has_data   = (count_q != '0);
  assign ex_ready_o = (count_q < CntW'(Depth));
  assign count_o    = count_q;

  // Results with no register target (or x0) are consumed but never stored.
  assign accept  = ex_valid_i & ex_ready_o;
  assign enq_req = accept & ex_we_i & (ex_rd_addr_i != 5'd0);
  assign pop     = has_data & rf_ready_i;

`ifdef IBEX_WB_BYPASS_EN
  logic bypass;

  // Empty buffer and a granted port: write the incoming result directly.
  assign bypass = enq_req & ~has_data & rf_ready_i;
  assign push   = enq_req & ~bypass;

  // Queued entries always go first; the bypass only fires when empty.
  always_comb begin
    rf_we_o    = has_data | bypass;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (has_data) begin
      rf_waddr_o = rd_q[rd_ptr_q];
      rf_wdata_o = data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_waddr_o = ex_rd_addr_i;
      rf_wdata_o = ex_result_i;
    end
  end
`else
  assign push = enq_req;

  // Head entry is shown whenever the buffer holds anything; zeros when empty.
  always_comb begin
    rf_we_o    = has_data;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (has_data) begin
      rf_waddr_o = rd_q[rd_ptr_q];
      rf_wdata_o = data_q[rd_ptr_q];
    end
  end
`endif

  // Pointers, occupancy and valid bits. Flush beats any same-cycle push/pop;
  // a pop in that cycle has still been written because rf_we_o was already up.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Payload storage needs no reset; the valid bits say what is meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= ex_rd_addr_i;
      data_q[wr_ptr_q] <= ex_result_i;
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit_a_o  = 1'b0;
    fwd_data_a_o = '0;
    fwd_hit_b_o  = 1'b0;
    fwd_data_b_o = '0;
    fwd_idx      = '0;
    for (int i = 0; i < Depth; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if (valid_q[fwd_idx] && (fwd_raddr_a_i != 5'd0) &&
          (rd_q[fwd_idx] == fwd_raddr_a_i)) begin
        fwd_hit_a_o  = 1'b1;
        fwd_data_a_o = data_q[fwd_idx];
      end
      if (valid_q[fwd_idx] && (fwd_raddr_b_i != 5'd0) &&
          (rd_q[fwd_idx] == fwd_raddr_b_i)) begin
        fwd_hit_b_o  = 1'b1;
        fwd_data_b_o = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_ibex_wb_result_buffer.sv
// tb_ibex_wb_result_buffer
//
// Scoreboard bench for ibex_wb_result_buffer. A queue-based reference model
// predicts occupancy, readiness, forwarding and the next register file write;
// every expected write is pushed onto a scoreboard that a separate monitor
// pops whenever the DUT performs a granted write. Directed sequences are
// followed by a long randomized run with flushes and mid-run resets.
module tb_ibex_wb_result_buffer;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ex_valid_i;
  logic          ex_we_i;
  logic [4:0]    ex_rd_addr_i;
  logic [DW-1:0] ex_result_i;
  logic          ex_ready_o;
  logic          flush_i;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_ready_i;
  logic [4:0]    fwd_raddr_a_i;
  logic [4:0]    fwd_raddr_b_i;
  logic          fwd_hit_a_o;
  logic [DW-1:0] fwd_data_a_o;
  logic          fwd_hit_b_o;
  logic [DW-1:0] fwd_data_b_o;
  logic [CW-1:0] count_o;

  int tests_run = 0;
  int failures  = 0;

  entry_t model_q[$];
  entry_t sb_q[$];
  logic   last_ready;

  ibex_wb_result_buffer #(.Depth(DEPTH), .DataWidth(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ex_valid_i   (ex_valid_i),
    .ex_we_i      (ex_we_i),
    .ex_rd_addr_i (ex_rd_addr_i),
    .ex_result_i  (ex_result_i),
    .ex_ready_o   (ex_ready_o),
    .flush_i      (flush_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_ready_i   (rf_ready_i),
    .fwd_raddr_a_i(fwd_raddr_a_i),
    .fwd_raddr_b_i(fwd_raddr_b_i),
    .fwd_hit_a_o  (fwd_hit_a_o),
    .fwd_data_a_o (fwd_data_a_o),
    .fwd_hit_b_o  (fwd_hit_b_o),
    .fwd_data_b_o (fwd_data_b_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, predict from the model, check the
  // steady outputs, queue the expected write, then advance the model.
  task automatic applyStimulus(input logic v, input logic we,
                               input logic [4:0] rd, input logic [DW-1:0] d,
                               input logic rdy, input logic fl,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic rst_n);
    int            sz;
    logic          byp;
    logic          exp_ready;
    logic          exp_we;
    entry_t        exp_wr;
    logic          hit_a, hit_b;
    logic [DW-1:0] dat_a, dat_b;
    entry_t        e;

    @(negedge clk_i);
    ex_valid_i    = v;
    ex_we_i       = we;
    ex_rd_addr_i  = rd;
    ex_result_i   = d;
    rf_ready_i    = rdy;
    flush_i       = fl;
    fwd_raddr_a_i = ra;
    fwd_raddr_b_i = rb;
    rst_ni        = rst_n;
    #1;

    sz        = model_q.size();
    exp_ready = (sz < DEPTH);
    byp       = 1'b0;
`ifdef IBEX_WB_BYPASS_EN
    byp = (sz == 0) && v && we && (rd != 5'd0) && rdy;
`endif
    exp_we      = (sz != 0) || byp;
    exp_wr.rd   = 5'd0;
    exp_wr.data = '0;
    if (sz != 0) begin
      exp_wr = model_q[0];
    end else if (byp) begin
      exp_wr.rd   = rd;
      exp_wr.data = d;
    end

    hit_a = 1'b0; dat_a = '0;
    hit_b = 1'b0; dat_b = '0;
    foreach (model_q[i]) begin
      if (ra != 5'd0 && model_q[i].rd == ra) begin
        hit_a = 1'b1; dat_a = model_q[i].data;
      end
      if (rb != 5'd0 && model_q[i].rd == rb) begin
        hit_b = 1'b1; dat_b = model_q[i].data;
      end
    end

    checkOutput("ex_ready", DW'(ex_ready_o), DW'(exp_ready));
    checkOutput("count", DW'(count_o), DW'(sz));
    checkOutput("rf_we", DW'(rf_we_o), DW'(exp_we));
    checkOutput("rf_waddr", DW'(rf_waddr_o), DW'(exp_wr.rd));
    checkOutput("rf_wdata", rf_wdata_o, exp_wr.data);
    checkOutput("fwd_hit_a", DW'(fwd_hit_a_o), DW'(hit_a));
    checkOutput("fwd_data_a", fwd_data_a_o, dat_a);
    checkOutput("fwd_hit_b", DW'(fwd_hit_b_o), DW'(hit_b));
    checkOutput("fwd_data_b", fwd_data_b_o, dat_b);

    if (exp_we && rdy) sb_q.push_back(exp_wr);

    if (!rst_n) begin
      model_q.delete();
    end else begin
      if (sz != 0 && rdy) void'(model_q.pop_front());
      if (fl) begin
        model_q.delete();
      end else if (v && exp_ready && we && rd != 5'd0 && !byp) begin
        e.rd   = rd;
        e.data = d;
        model_q.push_back(e);
      end
    end
    last_ready = exp_ready;
  endtask

  // Monitor: every granted write must match the oldest expected write.
  initial begin
    entry_t exp_e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rf_we_o === 1'b1 && rf_ready_i === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rf_write: got rd=%0d data=%h expected no write at %0t",
                   rf_waddr_o, rf_wdata_o, $time);
        end else begin
          exp_e = sb_q.pop_front();
          if (rf_waddr_o !== exp_e.rd || rf_wdata_o !== exp_e.data) begin
            failures++;
            $display("[TB] FAIL rf_write: got rd=%0d data=%h expected rd=%0d data=%h at %0t",
                     rf_waddr_o, rf_wdata_o, exp_e.rd, exp_e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    logic          v, we, rdy, fl, rst_n, hold;
    logic [4:0]    rd;
    logic [DW-1:0] d;

    rst_ni        = 1'b0;
    ex_valid_i    = 1'b0;
    ex_we_i       = 1'b0;
    ex_rd_addr_i  = '0;
    ex_result_i   = '0;
    rf_ready_i    = 1'b0;
    flush_i       = 1'b0;
    fwd_raddr_a_i = '0;
    fwd_raddr_b_i = '0;
    repeat (3) @(negedge clk_i);

    // Reset state, then single result with a free port.
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 3, 1);
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 1, 0, 5, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 1);

    // Busy port: two results to the same register, youngest forwards.
    applyStimulus(1, 1, 3, 32'h11, 0, 0, 3, 3, 1);
    applyStimulus(1, 1, 3, 32'h22, 0, 0, 3, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 3, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 3, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 3, 1);

    // Dropped results: x0 destination and no-writeback.
    applyStimulus(1, 1, 0, 32'hAAAA, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 4, 32'hBBBB, 1, 0, 4, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 4, 0, 1);

    // Sustained push and pop every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 5'(i + 1), 32'h100 + i, 1, 0, 5'(i), 5'(i + 1), 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);

    // Flush while full with a stalled push, then flush with a live push.
    applyStimulus(1, 1, 1, 32'hA1, 0, 0, 1, 2, 1);
    applyStimulus(1, 1, 2, 32'hA2, 0, 0, 1, 2, 1);
    applyStimulus(1, 1, 7, 32'hA7, 0, 1, 7, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 7, 2, 1);
    applyStimulus(1, 1, 6, 32'hB6, 0, 0, 6, 0, 1);
    applyStimulus(1, 1, 8, 32'hB8, 1, 1, 8, 6, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 8, 6, 1);

    // Empty buffer, free port: zero latency only with the bypass built in.
    applyStimulus(1, 1, 9, 32'h55, 1, 0, 9, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 9, 0, 1);

    // Randomized run; EX holds a stalled result until it is accepted.
    hold = 1'b0;
    v = 0; we = 0; rd = 0; d = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 3) != 0);
        we = ($urandom_range(0, 7) != 0);
        rd = 5'($urandom_range(0, 7));
        d  = $urandom;
      end
      rdy   = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) begin
        v   = 1'b0;
        rdy = 1'b0;
      end
      applyStimulus(v, we, rd, d, rdy, fl, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), rst_n);
      hold = v && !last_ready;
    end

    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    @(negedge clk_i);
    #3;
    tests_run++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_writes: got %0d unwritten expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/ibex_wb_result_buffer.md
Name: ibex_wb_result_buffer

Overview:
- Writeback-side result buffer directly downstream of the execution block.
- Captures each completed EX result (ALU, mult/div or custom bloom op) with its destination register, queues it in order, and drains it to the register file write port whenever that port is free; the port is shared with the LSU and can be busy.
- Provides forwarding lookup of queued-but-unwritten results so ID operand reads stay coherent, and back-pressures EX when full.

Parameters:
- Depth, 2, number of queued results; power of two, >= 2.
- DataWidth, 32, result width in bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- ex_valid_i  in  1  EX result valid this cycle
- ex_we_i  in  1  result targets a register (0 = no writeback, e.g. store/branch)
- ex_rd_addr_i  in  5  destination register
- ex_result_i  in  DataWidth  result value
- ex_ready_o  out  1  buffer can accept a result this cycle
- flush_i  in  1  discard all queued results (exception or pipeline kill)
- rf_we_o  out  1  write request to register file
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  DataWidth  write data
- rf_ready_i  in  1  register file port granted this cycle (0 while LSU owns it)
- fwd_raddr_a_i  in  5  ID operand A register to look up
- fwd_raddr_b_i  in  5  ID operand B register to look up
- fwd_hit_a_o  out  1  operand A matches a queued entry
- fwd_data_a_o  out  DataWidth  youngest matching value, operand A
- fwd_hit_b_o  out  1  operand B matches a queued entry
- fwd_data_b_o  out  DataWidth  youngest matching value, operand B
- count_o  out  $clog2(Depth+1)  occupied entries

Behaviour:
- Reset values:
  - count_o = 0; rf_we_o = 0; rf_waddr_o = 0; rf_wdata_o = 0.
  - fwd_hit_a_o = fwd_hit_b_o = 0; fwd_data_a_o = fwd_data_b_o = 0.
  - Read and write pointers = 0; all entry valid bits = 0.
- Storage: circular FIFO of Depth entries {rd, data}. Read and write pointers are $clog2(Depth) bits and wrap modulo Depth. Occupancy counter is kept separately.
- ex_ready_o = (count_o < Depth). It is registered-state only, with no combinational path from rf_ready_i.
- Accept:
  - An accept is ex_valid_i & ex_ready_o.
  - Enqueue only if ex_we_i = 1 and ex_rd_addr_i != 0.
  - Otherwise the result is consumed and dropped: no state change, no write.
- Drain:
  - rf_we_o = (count_o != 0); rf_waddr_o and rf_wdata_o show the head entry.
  - A pop happens when rf_we_o & rf_ready_i.
  - When count_o = 0, rf_waddr_o and rf_wdata_o are driven 0.
- Latency: an enqueued result appears on the rf_* port on the cycle after accept, at the earliest.
- Simultaneous push and pop: count_o is unchanged and both pointers advance. This is legal at any occupancy below Depth.
- Full: while count_o = Depth, ex_ready_o = 0 even if a pop occurs the same cycle. EX must hold ex_valid_i and its data stable until ready.
- Forwarding:
  - Purely combinational over valid entries.
  - A hit requires raddr != 0 and raddr == entry rd.
  - With multiple matches, the youngest entry (nearest the write pointer) wins.
  - An entry popped this cycle still forwards this cycle.
  - The incoming ex_result_i is not forwarded; EX-to-ID forwarding stays in ID.
- Flush:
  - On the next edge: count_o = 0, pointers = 0, all valid bits cleared.
  - Flush has priority over a same-cycle push and pop. The pop's rf write still happens this cycle, because rf_we_o is already asserted.
- Reset mid-operation: all queued entries are lost with no rf write, identical to a flush.

Optional Feature:
- Macro: IBEX_WB_BYPASS_EN.
- Defined:
  - When count_o = 0, ex_valid_i = 1, ex_we_i = 1, ex_rd_addr_i != 0 and rf_ready_i = 1, the result drives rf_we_o, rf_waddr_o and rf_wdata_o in the same cycle and is not enqueued (zero latency).
  - If rf_ready_i = 0, the result is enqueued as normal.
  - rf_we_o becomes combinationally dependent on ex_valid_i.
- Undefined: no bypass path; latency is always >= 1 cycle and every rf_* output is driven from registers.

Test Plan:
- Reset, then rf_ready_i = 1: accept {rd=5, 0xDEADBEEF} -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF; following cycle count_o=0, rf_we_o=0.
- Hold rf_ready_i = 0 and push rd=3/0x11, then rd=3/0x22 -> count_o=2, ex_ready_o=0, fwd_raddr_a_i=3 gives hit with 0x22. Release rf_ready_i -> writes 0x11 then 0x22 in order; ex_ready_o returns to 1 after the first pop.
- Push with rd=0 and push with ex_we_i=0 -> count_o stays 0, no rf_we_o, ex_ready_o stays 1.
- Depth=2, sustained push and pop every cycle for 8 results -> count_o steady at 1, pointers wrap, rf writes in order with no bubbles after the first.
- Two entries queued, then flush_i together with ex_valid_i rd=7 -> next cycle count_o=0, rd=7 never written, fwd_hit_a_o=0 for rd=7.
- With IBEX_WB_BYPASS_EN, empty buffer, rf_ready_i=1, push rd=9/0x55 -> same-cycle rf_we_o=1, waddr=9, wdata=0x55; count_o remains 0.
